// File: rtl/trace_monitor.sv
// trace_monitor: streaming gridworld trajectory monitor with one-shot verdict (optional EARLY_EXIT_EN)
module trace_monitor #(
  parameter int H  = 48,
  parameter int CW = $clog2(H+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    x0,
  input  logic [2:0]    y0,
  input  logic          a_valid,
  input  logic [2:0]    a,
  output logic          a_ready,
  output logic [2:0]    pos_x,
  output logic [2:0]    pos_y,
  output logic [CW-1:0] steps,
  output logic          pending,
  output logic          done,
  output logic          accept
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic blue, yellow, brown, red, go, at_h, resolve, verdict, fire;
  logic [2:0] nx, ny;
`ifndef EARLY_EXIT_EN
  logic seen_red, yellow_ok;
`endif
  // colour sensing on the registered position
  always_comb begin
    blue   = (pos_x == 3'd3 || pos_x == 3'd4) && (pos_y >= 3'd2 && pos_y <= 3'd5);
    yellow = (pos_x == 3'd0 || pos_x == 3'd7) && (pos_y == 3'd0 || pos_y == 3'd7);
    brown  = (pos_x >= 3'd2 && pos_x <= 3'd5) && (pos_y == 3'd0 || pos_y == 3'd7);
    red    = ((pos_x == 3'd1 || pos_x == 3'd6) && (pos_y inside {3'd0, 3'd1, 3'd4, 3'd5}))
          || ((pos_x == 3'd0 || pos_x == 3'd7) && (pos_y inside {3'd1, 3'd4, 3'd5}));
  end
  // verdict resolution; the current cell is always included in the decision
  always_comb begin
    go   = start && state != RUN;
    at_h = steps == CW'(H);
`ifdef EARLY_EXIT_EN
    resolve = red | (yellow & ~pending) | at_h;
    verdict = ~red & yellow & ~pending;
`else
    resolve = at_h;
    verdict = (yellow_ok | (yellow & ~pending)) & ~(seen_red | red);
`endif
  end
  // saturating 2-D step rule
  always_comb begin
    nx = (a inside {3'd1, 3'd2, 3'd3}) ? (pos_x == 3'd7 ? pos_x : pos_x + 3'd1)
       : (a inside {3'd5, 3'd6, 3'd7}) ? (pos_x == 3'd0 ? pos_x : pos_x - 3'd1) : pos_x;
    ny = (a inside {3'd7, 3'd0, 3'd1}) ? (pos_y == 3'd7 ? pos_y : pos_y + 3'd1)
       : (a inside {3'd3, 3'd4, 3'd5}) ? (pos_y == 3'd0 ? pos_y : pos_y - 3'd1) : pos_y;
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next-state logic
  always_comb
    state_n = go ? RUN : (state == RUN && resolve) ? DONE : state;
  // outputs; no action is taken on the cycle the verdict resolves
  always_comb begin
    a_ready = state == RUN && !resolve;
    done    = state == DONE;
    fire    = a_valid & a_ready;
  end
  // position, step counter, pending flag and verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x   <= '0;
      pos_y   <= '0;
      steps   <= '0;
      pending <= 1'b0;
      accept  <= 1'b0;
    end else if (go) begin
      pos_x   <= x0;
      pos_y   <= y0;
      steps   <= '0;
      pending <= 1'b0;
      accept  <= 1'b0;
    end else if (state == RUN) begin
      pending <= blue ? 1'b0 : brown ? 1'b1 : pending;
      if (resolve) accept <= verdict;
      if (fire) begin
        pos_x <= nx;
        pos_y <= ny;
        steps <= steps + CW'(1);
      end
    end
  end
`ifndef EARLY_EXIT_EN
  // sticky trace flags evaluated at the horizon
  always_ff @(posedge clk) begin
    if (rst || go) begin
      seen_red  <= 1'b0;
      yellow_ok <= 1'b0;
    end else if (state == RUN) begin
      seen_red  <= seen_red | red;
      yellow_ok <= yellow_ok | (yellow & ~pending);
    end
  end
`endif
endmodule

// File: tb/tb_trace_monitor.sv
// tb_trace_monitor: directed self-checking bench for trace_monitor (H=4, either EARLY_EXIT_EN build)
module tb_trace_monitor;
  localparam int H = 4;
  localparam int CW = $clog2(H+1);
  logic clk = 0, rst = 1, start = 0, a_valid = 0, a_ready, pending, done, accept;
  logic [2:0] x0 = 0, y0 = 0, a = 0, pos_x, pos_y;
  logic [CW-1:0] steps;
  int checks = 0, errors = 0;

  trace_monitor #(.H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0),
    .a_valid(a_valid), .a(a), .a_ready(a_ready), .pos_x(pos_x), .pos_y(pos_y),
    .steps(steps), .pending(pending), .done(done), .accept(accept)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic begin_trace(input logic [2:0] x, input logic [2:0] y);
    start = 1; x0 = x; y0 = y;
    tick();
    start = 0;
  endtask

  task automatic act(input logic [2:0] code);
    a_valid = 1; a = code;
    tick();
    a_valid = 0;
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_pos_x", pos_x, 0);
    chk("rst_pos_y", pos_y, 0);
    chk("rst_steps", steps, 0);
    chk("rst_pending", pending, 0);
    chk("rst_done", done, 0);
    chk("rst_accept", accept, 0);
    chk("rst_a_ready", a_ready, 0);

    begin_trace(3'd1, 3'd0);
    chk("red_start_pos", {pos_x, pos_y}, {3'd1, 3'd0});
`ifdef EARLY_EXIT_EN
    tick();
    chk("red_done", done, 1);
    chk("red_accept", accept, 0);
    chk("red_steps", steps, 0);
`else
    act(3'd0); act(3'd0); act(3'd0); act(3'd0);
    chk("red_pos_y", pos_y, 4);
    tick();
    chk("red_done", done, 1);
    chk("red_accept", accept, 0);
    chk("red_steps", steps, 4);
`endif

    begin_trace(3'd1, 3'd7);
    chk("yel_restart_done", done, 0);
    act(3'd6);
    chk("yel_pos", {pos_x, pos_y}, {3'd0, 3'd7});
    chk("yel_steps1", steps, 1);
`ifdef EARLY_EXIT_EN
    tick();
    chk("yel_done", done, 1);
    chk("yel_accept", accept, 1);
    chk("yel_steps", steps, 1);
`else
    act(3'd2); act(3'd2); act(3'd2);
    tick();
    chk("yel_done", done, 1);
    chk("yel_accept", accept, 1);
    chk("yel_steps", steps, 4);
`endif

    begin_trace(3'd2, 3'd7);
    act(3'd6);
    chk("pend_set", pending, 1);
    act(3'd6);
    chk("pend_pos_yellow", {pos_x, pos_y}, {3'd0, 3'd7});
    act(3'd2);
    chk("pend_not_done", done, 0);
    act(3'd2);
    chk("pend_pos_end", {pos_x, pos_y}, {3'd2, 3'd7});
    tick();
    chk("pend_done", done, 1);
    chk("pend_accept", accept, 0);
    chk("pend_steps", steps, 4);

    begin_trace(3'd7, 3'd3);
    act(3'd2); act(3'd2); act(3'd2);
    chk("sat_pos", {pos_x, pos_y}, {3'd7, 3'd3});
    chk("sat_steps", steps, 3);
    chk("sat_not_done", done, 0);
    act(3'd2);
    tick();
    chk("sat_horizon_done", done, 1);
    chk("sat_horizon_accept", accept, 0);

    begin_trace(3'd3, 3'd0);
    tick();
    chk("blue_pend_set", pending, 1);
    act(3'd0);
    chk("blue_pos1", {pos_x, pos_y}, {3'd3, 3'd1});
    act(3'd0);
    tick();
    chk("blue_pos2", {pos_x, pos_y}, {3'd3, 3'd2});
    chk("blue_pend_clear", pending, 0);

    a = 3'd1;
    repeat (5) tick();
    chk("bp_steps", steps, 2);
    chk("bp_pos", {pos_x, pos_y}, {3'd3, 3'd2});
    chk("bp_ready", a_ready, 1);

    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", a_ready, 0);
    chk("mid_rst_steps", steps, 0);
    chk("mid_rst_pos", {pos_x, pos_y}, 0);
    begin_trace(3'd1, 3'd7);
    chk("post_rst_pos", {pos_x, pos_y}, {3'd1, 3'd7});
    chk("post_rst_ready", a_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
